// File: rtl/sample_sequencer_if.sv
// Handshake bundle between the sample sequencer and its ADC, processor and DAC neighbours.
// The master side drives ticks, control and stage responses; the slave side is the sequencer.
interface sample_sequencer_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned CNT_W  = 8
);
  logic              tick;
  logic              enable;
  logic              clr_err;
  logic              adc_start;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              proc_start;
  logic [DATA_W-1:0] sample_out;
  logic              proc_done;
  logic [DATA_W-1:0] proc_data;
  logic              dac_start;
  logic [DATA_W-1:0] dac_data;
  logic              busy;
  logic [CNT_W-1:0]  overrun_cnt;
  logic [CNT_W-1:0]  timeout_cnt;
  logic              timeout_flag;

  modport master (
    output tick, enable, clr_err, adc_valid, adc_data, proc_done, proc_data,
    input  adc_start, proc_start, sample_out, dac_start, dac_data, busy,
           overrun_cnt, timeout_cnt, timeout_flag
  );

  modport slave (
    input  tick, enable, clr_err, adc_valid, adc_data, proc_done, proc_data,
    output adc_start, proc_start, sample_out, dac_start, dac_data, busy,
           overrun_cnt, timeout_cnt, timeout_flag
  );
endinterface

// File: rtl/sample_sequencer.sv
// Per-sample scheduler: ADC conversion -> processor -> DAC frame, one sample per accepted tick,
// with stage timeouts and saturating overrun/abort counters.
module sample_sequencer #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned TIMEOUT    = 4095,
  parameter int unsigned DAC_CYCLES = 1200,
  parameter int unsigned CNT_W      = 8
) (
  input logic              sysclk,
  input logic              rst_n,
  sample_sequencer_if.slave bus
);

  localparam int unsigned TimerMax = (TIMEOUT > DAC_CYCLES) ? TIMEOUT : DAC_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT);
  localparam logic [TimerW-1:0] HoldLast   = TimerW'(DAC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StAdcWait, StProcWait, StDacHold} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              adc_start_q, adc_start_d;
  logic              proc_start_q, proc_start_d;
  logic              dac_start_q, dac_start_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  overrun_q, overrun_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic              flag_q, flag_d;

  logic go_adc, go_proc, go_dac, abort, overrun_evt;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      adc_start_q  <= 1'b0;
      proc_start_q <= 1'b0;
      dac_start_q  <= 1'b0;
      sample_q     <= '0;
      dac_q        <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= '0;
      timeout_q    <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      adc_start_q  <= adc_start_d;
      proc_start_q <= proc_start_d;
      dac_start_q  <= dac_start_d;
      sample_q     <= sample_d;
      dac_q        <= dac_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      flag_q       <= flag_d;
    end
  end

  // A response arriving on the timeout cycle is still accepted: valid/done is tested first.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TimerW'(1);
    go_adc  = 1'b0;
    go_proc = 1'b0;
    go_dac  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.tick && bus.enable) begin
          state_d = StAdcWait;
          go_adc  = 1'b1;
        end
      end
      StAdcWait: begin
        if (bus.adc_valid) begin
          state_d = StProcWait;
          timer_d = '0;
          go_proc = 1'b1;
        end else if (timer_q == TimeoutVal) begin
          state_d = StIdle;
          timer_d = '0;
          abort   = 1'b1;
        end
      end
      StProcWait: begin
        if (bus.proc_done) begin
          state_d = StDacHold;
          timer_d = '0;
          go_dac  = 1'b1;
        end else if (timer_q == TimeoutVal) begin
          state_d = StIdle;
          timer_d = '0;
          abort   = 1'b1;
        end
      end
      StDacHold: begin
        if (timer_q == HoldLast) begin
          state_d = StIdle;
          timer_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    overrun_evt  = bus.tick && (state_q != StIdle);
    adc_start_d  = go_adc;
    proc_start_d = go_proc;
    dac_start_d  = go_dac;
    sample_d     = go_proc ? bus.adc_data : sample_q;
    dac_d        = go_dac ? bus.proc_data : dac_q;
    busy_d       = (state_d != StIdle);
    // Clear wipes history, but an event in the same cycle still lands as a count of one.
    if (bus.clr_err) begin
      overrun_d = {{(CNT_W-1){1'b0}}, overrun_evt};
      timeout_d = {{(CNT_W-1){1'b0}}, abort};
      flag_d    = abort;
    end else begin
      overrun_d = (overrun_evt && (overrun_q != '1)) ? overrun_q + CNT_W'(1) : overrun_q;
      timeout_d = (abort && (timeout_q != '1)) ? timeout_q + CNT_W'(1) : timeout_q;
      flag_d    = flag_q | abort;
    end
  end

  assign bus.adc_start    = adc_start_q;
  assign bus.proc_start   = proc_start_q;
  assign bus.dac_start    = dac_start_q;
  assign bus.sample_out   = sample_q;
  assign bus.dac_data     = dac_q;
  assign bus.busy         = busy_q;
  assign bus.overrun_cnt  = overrun_q;
  assign bus.timeout_cnt  = timeout_q;
  assign bus.timeout_flag = flag_q;

endmodule
